// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the debug UART transmitter.
// DEBUG_UART_CHECKSUM_EN appends an XOR checksum byte to every frame.
package debug_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int         NUM_PORTS         = 7;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

`ifdef DEBUG_UART_CHECKSUM_EN
    localparam int FRAME_BYTES = NUM_PORTS + 2;
`else
    localparam int FRAME_BYTES = NUM_PORTS + 1;
`endif

endpackage

// File: rtl/debug_uart_byte_tx.sv
// Serialises one byte as 8N1, LSB first. o_done flags the last stop-bit cycle;
// asserting i_start in that cycle chains the next byte with no idle gap.
module debug_uart_byte_tx
    import debug_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_done
);

    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt;
    logic          w_expire;

    assign w_expire = (r_cnt == '0);
    assign o_tx     = r_tx;

    always_ff @(posedge clk) begin
        if (nreset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_state != IDLE && !w_expire) ? r_cnt - CW'(1) : r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_shift_nxt = i_data;
                    w_tx_nxt    = 1'b0;
                    w_cnt_nxt   = RELOAD;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_expire) begin
                    w_cnt_nxt   = RELOAD;
                    w_tx_nxt    = r_shift[0];
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_cnt_nxt = RELOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt   = r_bit_idx + 3'd1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_expire) begin
                    o_done = 1'b1;
                    if (i_start) begin
                        w_shift_nxt = i_data;
                        w_tx_nxt    = 1'b0;
                        w_cnt_nxt   = RELOAD;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Snapshots the seven debug ports on a trigger and sends SYNC + ports over UART.
// DEBUG_UART_CHECKSUM_EN adds a trailing XOR-of-ports checksum byte.
module debug_uart_tx
    import debug_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       trigger,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] dropped_count
);

    logic [NUM_PORTS-1:0][7:0] w_ports, r_snap;
    logic [3:0]                r_byte_idx, w_next_idx;
    logic [2:0]                w_port_sel;
    logic [7:0]                r_drop, w_data;
    logic                      r_busy, r_frame_done;
    logic                      w_start, w_done, w_more, w_tx;

    assign w_ports = {debug_port7, debug_port6, debug_port5, debug_port4,
                      debug_port3, debug_port2, debug_port1};

    assign w_more     = (r_byte_idx != 4'(FRAME_BYTES - 1));
    assign w_start    = r_busy ? (w_done && w_more) : trigger;
    assign w_next_idx = r_busy ? r_byte_idx + 4'd1 : 4'd0;
    assign w_port_sel = 3'(w_next_idx - 4'd1);

`ifdef DEBUG_UART_CHECKSUM_EN
    logic [7:0] w_csum;
    always_comb begin
        w_csum = '0;
        for (int i = 0; i < NUM_PORTS; i++) w_csum ^= r_snap[i];
    end
`endif

    // Byte 0 is the sync marker, so it never depends on the not-yet-latched snapshot.
    always_comb begin
        w_data = SYNC_BYTE;
        if (w_next_idx >= 4'd1 && w_next_idx <= 4'(NUM_PORTS)) w_data = r_snap[w_port_sel];
`ifdef DEBUG_UART_CHECKSUM_EN
        if (w_next_idx == 4'(NUM_PORTS + 1)) w_data = w_csum;
`endif
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            r_snap       <= '0;
            r_byte_idx   <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop       <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (!r_busy) begin
                if (trigger) begin
                    r_snap     <= w_ports;
                    r_byte_idx <= '0;
                    r_busy     <= 1'b1;
                end
            end else begin
                if (trigger && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
                if (w_done) begin
                    if (w_more) begin
                        r_byte_idx <= r_byte_idx + 4'd1;
                    end else begin
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
            end
        end
    end

    debug_uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
        .clk     (clk),
        .nreset  (nreset),
        .i_start (w_start),
        .i_data  (w_data),
        .o_tx    (w_tx),
        .o_done  (w_done)
    );

    assign tx            = w_tx;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign dropped_count = r_drop;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed/random bench: expected waveform is built from the frame's byte list.
module tb_debug_uart_tx;

    localparam int CPB = 4;
`ifdef DEBUG_UART_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int LEN = NB * 10 * CPB;

    logic       clk = 1'b0;
    logic       nreset, trig;
    logic [7:0] port [0:6];
    logic       tx, busy, frame_done;
    logic [7:0] dropped_count;

    int n_pass = 0;
    int n_total = 0;
    int drop_exp = 0;

    always #5 clk = ~clk;

    debug_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .trigger       (trig),
        .debug_port1   (port[0]),
        .debug_port2   (port[1]),
        .debug_port3   (port[2]),
        .debug_port4   (port[3]),
        .debug_port5   (port[4]),
        .debug_port6   (port[5]),
        .debug_port7   (port[6]),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done),
        .dropped_count (dropped_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic rand_ports();
        for (int i = 0; i < 7; i++) port[i] = 8'($urandom);
    endtask

    // Triggers a frame, holds trigger high for 'drops' busy cycles, optionally
    // retriggers on the closing edge, and optionally scrambles the ports mid-frame.
    task automatic run_frame(input int drops, input bit end_trig, input bit scramble);
        logic [7:0] expb [0:NB-1];
        logic       cap  [0:LEN-1];
        logic [7:0] val;
        logic       bitv;
        int         bad, wbad, base;
        expb[0] = 8'hA5;
        for (int i = 0; i < 7; i++) expb[i+1] = port[i];
`ifdef DEBUG_UART_CHECKSUM_EN
        expb[8] = port[0] ^ port[1] ^ port[2] ^ port[3] ^ port[4] ^ port[5] ^ port[6];
`endif
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("tx_fall", 32'(tx), 32'd0);
        chk("busy_rise", 32'(busy), 32'd1);
        bad = 0;
        for (int k = 0; k < LEN; k++) begin
            cap[k] = tx;
            if (busy !== 1'b1 || frame_done !== 1'b0) bad++;
            if (scramble && k == 10 * CPB) begin
                rand_ports();
                port[2] = 8'hFF;
            end
            trig = (k >= 1 && k < 1 + drops) || (end_trig && k == LEN - 1);
            tick();
        end
        trig = 1'b0;
        chk("busy_fall", 32'(busy), 32'd0);
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("tx_idle_end", 32'(tx), 32'd1);
        chk("ctrl_in_frame", 32'(bad), 32'd0);
        wbad = 0;
        for (int b = 0; b < NB; b++)
            for (int j = 0; j < 10; j++) begin
                bitv = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : expb[b][j-1];
                for (int c = 0; c < CPB; c++)
                    if (cap[b*10*CPB + j*CPB + c] !== bitv) wbad++;
            end
        chk("waveform", 32'(wbad), 32'd0);
        for (int b = 0; b < NB; b++) begin
            base = b * 10 * CPB;
            for (int i = 0; i < 8; i++) val[i] = cap[base + (i+1)*CPB + CPB/2];
            chk($sformatf("byte%0d", b), 32'(val), 32'(expb[b]));
        end
        drop_exp = drop_exp + drops + int'(end_trig);
        if (drop_exp > 255) drop_exp = 255;
        chk("dropped", 32'(dropped_count), 32'(drop_exp));
        tick();
        chk("done_pulse_1cyc", 32'(frame_done), 32'd0);
    endtask

    initial begin
        int bad;
        nreset = 1'b1;
        trig   = 1'b0;
        for (int i = 0; i < 7; i++) port[i] = 8'h00;

        // reset
        tick();
        tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_drop", 32'(dropped_count), 32'd0);
        nreset = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle_100", 32'(bad), 32'd0);

        // single frame, ports 01..07
        for (int i = 0; i < 7; i++) port[i] = 8'(i + 1);
        run_frame(0, 1'b0, 1'b0);

        // snapshot freeze: port3 goes to FF during byte 1
        for (int i = 0; i < 7; i++) port[i] = 8'(i + 1);
        run_frame(0, 1'b0, 1'b1);

`ifdef DEBUG_UART_CHECKSUM_EN
        port[0] = 8'h01;
        for (int i = 1; i < 7; i++) port[i] = 8'h00;
        run_frame(0, 1'b0, 1'b0);
`endif

        // drop counting, including a trigger on the closing edge
        rand_ports();
        run_frame(3, 1'b0, 1'b0);
        rand_ports();
        run_frame(2, 1'b1, 1'b0);
        rand_ports();
        run_frame($urandom_range(20, 60), 1'b0, 1'b1);
        rand_ports();
        run_frame(300, 1'b0, 1'b0);
        rand_ports();
        run_frame(5, 1'b1, 1'b0);

        // mid-frame reset during byte 4 data bits
        rand_ports();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int k = 0; k < 4*10*CPB + 2*CPB + 1; k++) tick();
        nreset = 1'b1;
        tick();
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_drop", 32'(dropped_count), 32'd0);
        drop_exp = 0;
        nreset = 1'b0;
        tick();
        rand_ports();
        run_frame(0, 1'b0, 1'b0);

        for (int r = 0; r < 2; r++) begin
            rand_ports();
            run_frame($urandom_range(0, 10), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
